// File: rtl/bomb_if.sv
// Bomb engine port bundle: pixel/bomberman coordinates and drop button in,
// pixel-mux colours, block-map clear writes and status out.
interface bomb_if;
  logic [9:0]  x_a;
  logic [9:0]  y_a;
  logic [9:0]  x_bm;
  logic [9:0]  y_bm;
  logic        A;
  logic        bomb_on;
  logic [11:0] bomb_rgb;
  logic        exp_on;
  logic [11:0] exp_rgb;
  logic        block_we;
  logic [9:0]  block_w_addr;
  logic        bomb_active;
  logic        post_exp_active;

  modport master (
    output x_a, y_a, x_bm, y_bm, A,
    input  bomb_on, bomb_rgb, exp_on, exp_rgb, block_we, block_w_addr,
           bomb_active, post_exp_active
  );

  modport slave (
    input  x_a, y_a, x_bm, y_bm, A,
    output bomb_on, bomb_rgb, exp_on, exp_rgb, block_we, block_w_addr,
           bomb_active, post_exp_active
  );
endinterface

// File: rtl/bomb_module.sv
// Single-bomb engine: drop on bomberman's tile, fuse, plus-shaped explosion
// that clears blocks, then a one-cycle post-explosion pulse.
//
// state   | meaning
// IDLE    | no bomb; waiting for a rising edge on A
// ARMED   | bomb placed, fuse counter running
// EXPLODE | plus shown; block-clear writes in the first five cycles
// POST    | one-cycle post_exp_active pulse
module bomb_module #(
  parameter int TILE        = 16,
  parameter int COLS        = 33,
  parameter int ROWS        = 27,
  parameter int FUSE_CYCLES = 200000000,
  parameter int EXP_CYCLES  = 50000000
) (
  input logic   clk,
  input logic   reset,
  bomb_if.slave bif
);

  localparam int TSH     = $clog2(TILE);
  localparam int CNT_MAX = (FUSE_CYCLES > EXP_CYCLES) ? FUSE_CYCLES : EXP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX);
  localparam logic [CW-1:0] FUSE_LAST = CW'(FUSE_CYCLES - 1);
  localparam logic [CW-1:0] EXP_LAST  = CW'(EXP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ARMED, EXPLODE, POST} state_t;

  state_t          state_q, state_n;
  logic [CW-1:0]   cnt_q, cnt_n;
  logic            a_q;
  logic [5:0]      col_q, col_n, row_q, row_n;
  logic            we_q, we_n;
  logic [9:0]      addr_q, addr_n;

  logic            drop;
  logic [10:0]     col_raw, row_raw;
  logic [5:0]      col_clamp, row_clamp;
  logic [5:0]      cand_col, cand_row;
  logic            cand_ok;
  logic [9:0]      cand_addr;

  assign drop = bif.A & ~a_q;

  // Round the sprite's top-left to the tile under its centre.
  assign col_raw   = ({1'b0, bif.x_bm} + 11'(TILE / 2)) >> TSH;
  assign row_raw   = ({1'b0, bif.y_bm} + 11'(TILE / 2)) >> TSH;
  assign col_clamp = (col_raw > 11'(COLS - 1)) ? 6'(COLS - 1) : col_raw[5:0];
  assign row_clamp = (row_raw > 11'(ROWS - 1)) ? 6'(ROWS - 1) : row_raw[5:0];

  // Write order: centre, up, right, down, left.
  always_comb begin
    cand_col = col_q;
    cand_row = row_q;
    cand_ok  = 1'b1;
    case (cnt_q[2:0])
      3'd1: begin cand_row = row_q - 6'd1; cand_ok = (row_q != 6'd0);          end
      3'd2: begin cand_col = col_q + 6'd1; cand_ok = (col_q < 6'(COLS - 1));   end
      3'd3: begin cand_row = row_q + 6'd1; cand_ok = (row_q < 6'(ROWS - 1));   end
      3'd4: begin cand_col = col_q - 6'd1; cand_ok = (col_q != 6'd0);          end
      default: ;
    endcase
  end

  assign cand_addr = 10'(cand_row) * 10'(COLS) + 10'(cand_col);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      a_q     <= bif.A;
      col_q   <= col_n;
      row_q   <= row_n;
      we_q    <= we_n;
      addr_q  <= addr_n;
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    col_n   = col_q;
    row_n   = row_q;
    we_n    = 1'b0;
    addr_n  = addr_q;
    unique case (state_q)
      IDLE: begin
        if (drop) begin
          col_n   = col_clamp;
          row_n   = row_clamp;
          cnt_n   = '0;
          state_n = ARMED;
        end
      end
      ARMED: begin
        if (cnt_q == FUSE_LAST) begin
          cnt_n   = '0;
          state_n = EXPLODE;
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      EXPLODE: begin
        cnt_n = cnt_q + CW'(1);
        if (cnt_q < CW'(5)) begin
          we_n = cand_ok;
          if (cand_ok) addr_n = cand_addr;
        end
        if (cnt_q == EXP_LAST) begin
          cnt_n   = '0;
          state_n = POST;
        end
      end
      POST:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  logic [9:0]     px_col, px_row, col_w, row_w;
  logic [TSH-1:0] ox, oy;
  logic           band_x, band_y;
  logic           hit_c, hit_u, hit_r, hit_d, hit_l;

  assign px_col = bif.x_a >> TSH;
  assign px_row = bif.y_a >> TSH;
  assign ox     = bif.x_a[TSH-1:0];
  assign oy     = bif.y_a[TSH-1:0];
  assign col_w  = 10'(col_q);
  assign row_w  = 10'(row_q);

  assign hit_c = (px_col == col_w) && (px_row == row_w);
  assign hit_u = (row_q != 6'd0) && (px_col == col_w) && (px_row == row_w - 10'd1);
  assign hit_r = (col_q < 6'(COLS - 1)) && (px_row == row_w) && (px_col == col_w + 10'd1);
  assign hit_d = (row_q < 6'(ROWS - 1)) && (px_col == col_w) && (px_row == row_w + 10'd1);
  assign hit_l = (col_q != 6'd0) && (px_row == row_w) && (px_col == col_w - 10'd1);

  // Corner bands leave the bomb sprite with rounded-off transparent corners.
  assign band_x = (ox < TSH'(TILE / 4)) || (ox >= TSH'(TILE - TILE / 4));
  assign band_y = (oy < TSH'(TILE / 4)) || (oy >= TSH'(TILE - TILE / 4));

  assign bif.bomb_on         = (state_q == ARMED) && hit_c;
  assign bif.bomb_rgb        = (band_x && band_y) ? 12'h801 : 12'h111;
  assign bif.exp_on          = (state_q == EXPLODE) && (hit_c || hit_u || hit_r || hit_d || hit_l);
  assign bif.exp_rgb         = bif.exp_on ? 12'hFA0 : 12'h800;
  assign bif.block_we        = we_q;
  assign bif.block_w_addr    = addr_q;
  assign bif.bomb_active     = (state_q == ARMED);
  assign bif.post_exp_active = (state_q == POST);

endmodule

// File: doc/bomb_module.md
Name: bomb_module

Overview:
- Bomb/explosion engine that feeds the top-level pixel mux: produces bomb_on/bomb_rgb and exp_on/exp_rgb for the current arena pixel.
- On a drop request it places one bomb on the tile under bomberman, runs a fuse timer, then explodes in a plus shape.
- During the explosion it issues block-clear writes to the block map, then pulses post_exp_active.
- Only one bomb can exist at a time.

Parameters:
- TILE, 16, tile edge in pixels (power of 2).
- COLS, 33, arena width in tiles.
- ROWS, 27, arena height in tiles.
- FUSE_CYCLES, 200000000, clock cycles from drop to explosion.
- EXP_CYCLES, 50000000, clock cycles the explosion is displayed.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous active-high reset.
- x_a  input  10  current pixel x in arena coordinates.
- y_a  input  10  current pixel y in arena coordinates.
- x_bm  input  10  bomberman top-left x, arena coordinates.
- y_bm  input  10  bomberman top-left y, arena coordinates.
- A  input  1  debounced drop button, level.
- bomb_on  output  1  pixel lies inside the armed bomb tile.
- bomb_rgb  output  12  bomb colour; 12'h801 = transparent.
- exp_on  output  1  pixel lies inside the explosion plus.
- exp_rgb  output  12  explosion colour; 12'h800 = transparent.
- block_we  output  1  one-cycle block-clear write strobe.
- block_w_addr  output  10  tile index for the write, row*COLS+col.
- bomb_active  output  1  state is ARMED.
- post_exp_active  output  1  one-cycle pulse when the explosion ends.

Behaviour:
- Clock is clk; reset is synchronous, active-high.
- Reset values:
  - state = IDLE; all counters = 0; A edge register = 0.
  - block_we = 0, block_w_addr = 0, post_exp_active = 0.
  - bomb_on and exp_on = 0, because they are derived from the state.
- Drop detect:
  - Registered copy of A; a drop is A & ~A_q.
  - Holding A produces exactly one drop.
  - A drop in any state other than IDLE is ignored.
- IDLE + drop:
  - Latch bomb tile: col = (x_bm + TILE/2) / TILE, row = (y_bm + TILE/2) / TILE.
  - Clamp col to COLS-1 and row to ROWS-1.
  - Clear fuse counter; next state ARMED.
- ARMED:
  - Fuse counter increments each cycle.
  - When the counter = FUSE_CYCLES-1, go to EXPLODE and clear the counter.
  - ARMED therefore lasts exactly FUSE_CYCLES cycles.
- EXPLODE:
  - Counter increments each cycle; when it = EXP_CYCLES-1, go to POST.
  - In EXPLODE cycles 0..4, one candidate per cycle, in order: centre, up (row-1), right (col+1), down (row+1), left (col-1).
  - block_we = 1 with block_w_addr = candidate index only if the candidate is inside 0..COLS-1 / 0..ROWS-1; otherwise block_we = 0 that cycle.
  - The write outputs are registered: the first write is visible in the cycle after the state becomes EXPLODE.
  - EXP_CYCLES must be >= 6.
- POST: post_exp_active = 1 for exactly one cycle, then IDLE. A drop seen in POST is ignored.
- Pixel outputs (combinational from x_a, y_a and registered state; zero latency):
  - px_col = x_a / TILE, px_row = y_a / TILE; ox = x_a mod TILE, oy = y_a mod TILE.
  - bomb_on = (state == ARMED) & px_col == col & px_row == row.
  - bomb_rgb = 12'h801 when ox and oy both lie in a TILE/4 corner band (all four corners); else 12'h111.
  - exp_on = (state == EXPLODE) & pixel tile is the centre or a valid in-grid neighbour.
  - exp_rgb = 12'hFA0 when exp_on, else 12'h800.
- Width rules:
  - Neighbour arithmetic uses 6-bit col/row with explicit underflow check (row==0 → up invalid, col==0 → left invalid).
  - Address computed as row*COLS+col, truncated to 10 bits; COLS*ROWS must be <= 1024.
- Reset mid-operation: a reset in ARMED or EXPLODE returns to IDLE next cycle; any write burst in progress is aborted and block_we = 0 from that cycle onward.

Test Plan (FUSE_CYCLES=20, EXP_CYCLES=10, defaults otherwise):
1. x_bm=40, y_bm=40, pulse A → col=row=3; bomb_active high for exactly 20 cycles; bomb_on=1 at x_a=50,y_a=55; bomb_rgb=12'h801 at x_a=48,y_a=48.
2. Same drop, run to EXPLODE → block_we pulses with addr 102, 69, 103, 135, 101 on consecutive cycles; exp_on=1 at tile (4,3), 0 at (5,3); post_exp_active a single pulse 10 cycles after explosion entry.
3. x_bm=0, y_bm=0 → tile (0,0); only 3 writes (addr 0, 1, 33) while the strobe window stays 5 cycles; exp_on covers tiles (0,0), (1,0), (0,1) only.
4. Hold A high 100 cycles from IDLE, plus a second rising edge during ARMED → exactly one bomb; fuse timing unchanged.
5. Assert reset at ARMED cycle 10, and separately at EXPLODE cycle 2 → IDLE next cycle; no further block_we; bomb_on and exp_on = 0.
6. x_bm=530, y_bm=420 → tile clamped to (32,26); addr 890; right and down writes suppressed.
